sdiv_iter: RTL and testbench

- Iterative signed divider that inverts the array's 8x8 signed multiplier.
- Takes a 16-bit signed dividend (product domain) and an 8-bit signed divisor (operand domain). Returns a 16-bit signed quotient and an 8-bit signed remainder.
- Used for requantisation/normalisation of accumulator outputs and for round-trip checks of multiplier results.
- Same sign-magnitude strategy as the multiplier: divide the magnitudes unsigned, one restoring step per cycle, then apply signs.

---
 rtl/sdiv_iter.sv | 137 +++++++++++++
 tb/tb_sdiv_iter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdiv_iter.sv
// Iterative signed divider: 16-bit dividend by 8-bit divisor, computed as sign-magnitude
// restoring division with one quotient bit per cycle.
module sdiv_iter #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero,
   output logic                  overflow
);

   localparam int CNT_W = $clog2(DIVIDEND_W);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    sign_a_q, sign_a_d;
   logic                    sign_b_q, sign_b_d;
   logic [DIVIDEND_W-1:0]   a_q, a_d;
   logic [DIVISOR_W-1:0]    b_q, b_d;
   logic [DIVISOR_W-1:0]    part_q, part_d;
   logic [DIVIDEND_W-1:0]   quot_q, quot_d;
   logic [DIVISOR_W-1:0]    rem_q, rem_d;
   logic                    dbz_q, dbz_d;
   logic                    ovf_q, ovf_d;
   logic [DIVISOR_W:0]      trial;
   logic                    ge;

   function automatic logic [DIVIDEND_W-1:0] mag_a(input logic [DIVIDEND_W-1:0] v);
      return v[DIVIDEND_W-1] ? -v : v;
   endfunction

   function automatic logic [DIVISOR_W-1:0] mag_b(input logic [DIVISOR_W-1:0] v);
      return v[DIVISOR_W-1] ? -v : v;
   endfunction

   // a_q holds the unconsumed dividend magnitude bits in its top and collects
   // quotient bits from the bottom; after DIVIDEND_W steps it is the quotient magnitude.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      a_d      = a_q;
      b_d      = b_q;
      part_d   = part_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dbz_d    = dbz_q;
      ovf_d    = ovf_q;
      trial    = {part_q, a_q[DIVIDEND_W-1]};
      ge       = (trial >= {1'b0, b_q});
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_a_d = dividend[DIVIDEND_W-1];
               sign_b_d = divisor[DIVISOR_W-1];
               a_d      = mag_a(dividend);
               b_d      = mag_b(divisor);
               part_d   = '0;
               cnt_d    = '0;
               dbz_d    = 1'b0;
               ovf_d    = 1'b0;
               if (divisor == '0) begin
                  quot_d  = '1;
                  rem_d   = '0;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            part_d = ge ? DIVISOR_W'(trial - {1'b0, b_q}) : trial[DIVISOR_W-1:0];
            a_d    = {a_q[DIVIDEND_W-2:0], ge};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIVIDEND_W - 1)) state_d = FIX;
         end
         FIX: begin
            quot_d  = (sign_a_q ^ sign_b_q) ? -a_q : a_q;
            rem_d   = sign_a_q ? -part_q : part_q;
            // Only -2^(W-1) / -1 yields a positive magnitude of 2^(W-1).
            ovf_d   = a_q[DIVIDEND_W-1] & ~(sign_a_q ^ sign_b_q);
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clock) begin
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_sdiv_iter.sv
// Bench for sdiv_iter: vector table, multi-cycle corner sequences and random pairs
// checked against an integer division model through a scoreboard queue.
module tb_sdiv_iter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;
   logic        overflow;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        dbz;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [15:0] q;
      logic [7:0]  r;
      logic        dbz;
      logic        ovf;
   } vec_t;

   exp_t sbq[$];

   sdiv_iter #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
      exp_t e;
      int sa, sb, q, r;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 8'h00) begin
         e.q = 16'hFFFF; e.r = 8'h00; e.dbz = 1'b1; e.ovf = 1'b0;
      end else begin
         q = sa / sb;
         r = sa % sb;
         e.q = q[15:0]; e.r = r[7:0]; e.dbz = 1'b0; e.ovf = (q > 32767);
      end
      return e;
   endfunction

   // One operation: accept, wait for result (bounded), optional backpressure hold,
   // optional input toggling while busy, compare against the scoreboard, consume.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input exp_t e, input int exp_lat, input int hold, input bit toggle,
                         output logic [15:0] q_obs, output logic [7:0] r_obs,
                         output logic dbz_obs);
      int lat;
      int w;
      bit busy_bad;
      exp_t got;
      logic [15:0] q0;
      logic [7:0]  r0;
      logic        f0;
      bit          stable;
      q_obs = '0; r_obs = '0; dbz_obs = 1'b0;
      @(negedge clock);
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clock); w++; end
      if (!in_ready) begin
         chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
         return;
      end
      dividend = a; divisor = b; in_valid = 1'b1;
      out_ready = (hold == 0);
      sbq.push_back(e);
      @(posedge clock);
      #1 in_valid = 1'b0;
      lat = 0;
      busy_bad = 1'b0;
      do begin
         @(negedge clock);
         lat++;
         if (!out_valid) begin
            if (in_ready) busy_bad = 1'b1;
            if (toggle) begin
               in_valid = 1'($urandom);
               dividend = 16'($urandom);
               divisor  = 8'($urandom);
            end
         end
      end while (!out_valid && lat < 40);
      in_valid = 1'b0;
      if (!out_valid) begin
         chk({tag, "_result_timeout"}, 32'(out_valid), 32'd1);
         void'(sbq.pop_front());
         out_ready = 1'b0;
         return;
      end
      if (exp_lat > 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      if (toggle) chk({tag, "_busy_in_ready"}, 32'(busy_bad), 32'd0);
      if (hold > 0) begin
         q0 = quotient; r0 = remainder; f0 = div_by_zero;
         stable = 1'b1;
         repeat (hold) begin
            @(negedge clock);
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== f0 ||
                !out_valid || in_ready) stable = 1'b0;
         end
         chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
         out_ready = 1'b1;
      end
      if (sbq.size() == 0) begin
         chk({tag, "_scoreboard_empty"}, 32'(sbq.size()), 32'd1);
      end else begin
         got = sbq.pop_front();
         chk({tag, "_quotient"}, 32'(quotient), 32'(got.q));
         chk({tag, "_remainder"}, 32'(remainder), 32'(got.r));
         chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(got.dbz));
         chk({tag, "_overflow"}, 32'(overflow), 32'(got.ovf));
      end
      q_obs = quotient; r_obs = remainder; dbz_obs = div_by_zero;
      @(posedge clock);
      @(negedge clock);
      chk({tag, "_after_consume"}, {30'd0, out_valid, in_ready}, 32'b01);
      out_ready = 1'b0;
   endtask

   vec_t vecs[$];

   initial begin
      exp_t e;
      logic [15:0] qo;
      logic [7:0]  ro;
      logic        zo;
      logic [15:0] ra;
      logic [7:0]  rb;
      int qi, bi, ri, prod;
      bit stale;

      vecs.push_back('{16'd100,  8'd7,   16'd14,   8'd2,   1'b0, 1'b0});
      vecs.push_back('{16'hFF9C, 8'd7,   16'hFFF2, 8'hFE,  1'b0, 1'b0});
      vecs.push_back('{16'd100,  8'hF9,  16'hFFF2, 8'h02,  1'b0, 1'b0});
      vecs.push_back('{16'hFF9C, 8'hF9,  16'd14,   8'hFE,  1'b0, 1'b0});
      vecs.push_back('{16'h4000, 8'h80,  16'hFF80, 8'h00,  1'b0, 1'b0});
      vecs.push_back('{16'h8000, 8'hFF,  16'h8000, 8'h00,  1'b0, 1'b1});
      vecs.push_back('{16'h8000, 8'h01,  16'h8000, 8'h00,  1'b0, 1'b0});
      vecs.push_back('{16'h7FFF, 8'h01,  16'h7FFF, 8'h00,  1'b0, 1'b0});
      vecs.push_back('{16'h7FFF, 8'h80,  16'hFF01, 8'h7F,  1'b0, 1'b0});
      vecs.push_back('{16'h8000, 8'h80,  16'h0100, 8'h00,  1'b0, 1'b0});
      vecs.push_back('{16'h0000, 8'd5,   16'h0000, 8'h00,  1'b0, 1'b0});

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_quotient", 32'(quotient), 32'd0);
      chk("reset_remainder", 32'(remainder), 32'd0);
      chk("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);

      foreach (vecs[i]) begin
         e = '{vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf};
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, e, 18, 0, 1'b0, qo, ro, zo);
      end

      e = '{16'hFFFF, 8'h00, 1'b1, 1'b0};
      run_op("dbz", 16'd1234, 8'd0, e, 1, 0, 1'b0, qo, ro, zo);
      e = '{16'd3, 8'd1, 1'b0, 1'b0};
      run_op("after_dbz", 16'd10, 8'd3, e, 18, 0, 1'b0, qo, ro, zo);

      e = '{16'd14, 8'd2, 1'b0, 1'b0};
      run_op("backpressure", 16'd100, 8'd7, e, 18, 5, 1'b0, qo, ro, zo);
      e = '{16'hFFF2, 8'hFE, 1'b0, 1'b0};
      run_op("toggle", 16'hFF9C, 8'd7, e, 18, 0, 1'b1, qo, ro, zo);

      // Abort an operation mid-CALC; its result must never appear.
      @(negedge clock);
      dividend = 16'd5000; divisor = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      repeat (8) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("midcalc_reset_in_ready", 32'(in_ready), 32'd1);
      chk("midcalc_reset_out_valid", 32'(out_valid), 32'd0);
      stale = 1'b0;
      repeat (25) begin
         @(negedge clock);
         if (out_valid) stale = 1'b1;
      end
      chk("midcalc_no_stale_result", 32'(stale), 32'd0);
      out_ready = 1'b0;
      e = '{16'hFFFD, 8'hFF, 1'b0, 1'b0};
      run_op("after_reset", 16'hFFF9, 8'd2, e, 18, 0, 1'b0, qo, ro, zo);

      for (int k = 0; k < 2000; k++) begin
         ra = 16'($urandom);
         rb = (k % 97 == 0) ? 8'h00 : 8'($urandom);
         e = model(ra, rb);
         run_op($sformatf("rnd%0d", k), ra, rb, e, 0, 0, 1'b0, qo, ro, zo);
         if (!zo) begin
            qi = $signed(qo);
            bi = $signed(rb);
            ri = $signed(ro);
            prod = qi * bi + ri;
            chk($sformatf("rnd%0d_invariant", k), 32'(prod[15:0]), 32'(ra));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
